// File: rtl/alu_arbiter_pkg.sv
// Shared definitions for the two-requester accumulator ALU: widths, opcodes,
// controller states and the captured-operation record.
package alu_arbiter_pkg;
  localparam int DATA_W = 4;
  localparam int RES_W  = 2 * DATA_W;

  localparam logic [2:0] OP_MUL   = 3'b000;
  localparam logic [2:0] OP_SHR   = 3'b001;
  localparam logic [2:0] OP_SHL   = 3'b010;
  localparam logic [2:0] OP_ORRED = 3'b011;
  localparam logic [2:0] OP_ORXOR = 3'b100;
  localparam logic [2:0] OP_ADD   = 3'b101;
  localparam logic [2:0] OP_ADD2  = 3'b110;
  localparam logic [2:0] OP_INC   = 3'b111;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_GRANT = 2'd1,
    ST_EXEC  = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  typedef struct packed {
    logic [2:0]        func;
    logic [DATA_W-1:0] data;
  } op_t;
endpackage

// File: rtl/alu_arbiter_core.sv
// Combinational ALU: one opcode, latched operand d and accumulator nibble a
// produce a zero-extended RES_W result.
module alu_core
  import alu_arbiter_pkg::*;
#(
  parameter int DATA_W = alu_arbiter_pkg::DATA_W,
  parameter int RES_W  = alu_arbiter_pkg::RES_W
) (
  input  logic [2:0]        func,
  input  logic [DATA_W-1:0] d,
  input  logic [DATA_W-1:0] a,
  output logic [RES_W-1:0]  res
);
  logic [RES_W-1:0] dz, az;

  assign dz = RES_W'(d);
  assign az = RES_W'(a);

  // Shifts are done at full result width so oversized shift counts fall to zero.
  always_comb begin
    res = '0;
    case (func)
      OP_INC:          res = dz + RES_W'(1);
      OP_ADD, OP_ADD2: res = dz + az;
      OP_ORXOR:        res = RES_W'({d | a, d ^ a});
      OP_ORRED:        res = RES_W'(|{d, a});
      OP_SHL:          res = az << d;
      OP_SHR:          res = az >> d;
      OP_MUL:          res = dz * az;
      default:         res = '0;
    endcase
  end
endmodule

// File: rtl/alu_arbiter.sv
// Round-robin shares one accumulator ALU between two requesters; a
// grant/exec/done controller runs one operation per grant.
module alu_arbiter
  import alu_arbiter_pkg::*;
#(
  parameter int DATA_W = alu_arbiter_pkg::DATA_W,
  parameter int RES_W  = alu_arbiter_pkg::RES_W
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [1:0]        req,
  input  logic [2:0]        func0,
  input  logic [2:0]        func1,
  input  logic [DATA_W-1:0] data0,
  input  logic [DATA_W-1:0] data1,
  output logic [1:0]        gnt,
  output logic              busy,
  output logic              owner,
  output logic              valid,
  output logic [RES_W-1:0]  result
);
  state_t           state, state_n;
  logic             rr;
  logic             owner_q;
  op_t              op;
  logic [RES_W-1:0] acc;
  logic [RES_W-1:0] alu_out;
  logic             any_req, pref, win, arb;

  // In DONE the pointer has not yet flipped, so the tie preference is
  // taken directly from the owner just served.
  assign any_req = |req;
  assign pref    = (state == ST_DONE) ? ~owner_q : rr;
  assign win     = (&req) ? pref : req[1];
  assign arb     = (state == ST_IDLE || state == ST_DONE) && any_req;

  alu_core #(.DATA_W(DATA_W), .RES_W(RES_W)) u_core (
    .func (op.func),
    .d    (op.data),
    .a    (acc[DATA_W-1:0]),
    .res  (alu_out)
  );

  always_comb begin
    state_n = state;
    case (state)
      ST_IDLE:  if (any_req) state_n = ST_GRANT;
      ST_GRANT: state_n = ST_EXEC;
      ST_EXEC:  state_n = ST_DONE;
      ST_DONE:  state_n = any_req ? ST_GRANT : ST_IDLE;
      default:  state_n = ST_IDLE;
    endcase
  end

  // The accumulator loads on the EXEC->DONE edge so the new value is
  // visible together with the valid strobe during DONE.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state   <= ST_IDLE;
      rr      <= 1'b0;
      owner_q <= 1'b0;
      op      <= '0;
      acc     <= '0;
    end else begin
      state <= state_n;
      if (arb) owner_q <= win;
      if (state == ST_DONE) rr <= ~owner_q;
      if (state == ST_GRANT) op <= owner_q ? op_t'{func1, data1} : op_t'{func0, data0};
      if (state == ST_EXEC) acc <= alu_out;
    end
  end

  assign gnt    = (state == ST_GRANT) ? (owner_q ? 2'b10 : 2'b01) : 2'b00;
  assign busy   = (state != ST_IDLE);
  assign valid  = (state == ST_DONE);
  assign owner  = owner_q;
  assign result = acc;
endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter: a cycle-level transaction model checked every
// cycle, plus literal expectations for the documented operation sequences.
module tb_alu_arbiter;
  logic       clk = 1'b0;
  logic       reset_n;
  logic [1:0] req;
  logic [2:0] func0, func1;
  logic [3:0] data0, data1;
  logic [1:0] gnt;
  logic       busy, owner, valid;
  logic [7:0] result;

  int n_cmp = 0;
  int n_bad = 0;
  bit chk_en = 1'b0;

  alu_arbiter dut (
    .clk(clk), .reset_n(reset_n), .req(req),
    .func0(func0), .func1(func1), .data0(data0), .data1(data1),
    .gnt(gnt), .busy(busy), .owner(owner), .valid(valid), .result(result)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Operation semantics from the opcode table, written in plain integers.
  function automatic int m_alu(input int f, input int d, input int a);
    case (f)
      7:       return d + 1;
      6, 5:    return d + a;
      4:       return (d | a) * 16 + (d ^ a);
      3:       return (d != 0 || a != 0) ? 1 : 0;
      2:       return (d >= 8) ? 0 : ((a * (1 << d)) % 256);
      1:       return (d >= 4) ? 0 : (a / (1 << d));
      default: return d * a;
    endcase
  endfunction

  // phase: 0 idle, 1 grant cycle, 2 execute cycle, 3 result cycle
  int ph, who, pref, mf, md, macc;

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ph <= 0; who <= 0; pref <= 0; mf <= 0; md <= 0; macc <= 0;
    end else begin
      case (ph)
        0: if (req != 0) begin
          who <= (req == 2'b11) ? pref : (req[1] ? 1 : 0);
          ph  <= 1;
        end
        1: begin
          mf <= who ? int'(func1) : int'(func0);
          md <= who ? int'(data1) : int'(data0);
          ph <= 2;
        end
        2: begin
          macc <= m_alu(mf, md, macc % 16);
          ph   <= 3;
        end
        default: begin
          pref <= 1 - who;
          if (req != 0) begin
            who <= (req == 2'b11) ? 1 - who : (req[1] ? 1 : 0);
            ph  <= 1;
          end else ph <= 0;
        end
      endcase
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("model_gnt", int'(gnt), (ph == 1) ? (who ? 2 : 1) : 0);
      chk("model_busy", int'(busy), (ph != 0) ? 1 : 0);
      chk("model_valid", int'(valid), (ph == 3) ? 1 : 0);
      chk("model_result", int'(result), macc);
      if (ph != 0) chk("model_owner", int'(owner), who);
    end
  end

  task automatic do_reset();
    reset_n = 1'b0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic do_op(input int i, input logic [2:0] f, input logic [3:0] d,
                       input int exp, output int lat_g, output int lat_v);
    if (i == 0) begin func0 = f; data0 = d; end
    else        begin func1 = f; data1 = d; end
    req[i] = 1'b1;
    lat_g = 0;
    do begin @(negedge clk); lat_g++; end while (!gnt[i] && lat_g < 20);
    if (!gnt[i]) chk("gnt_timeout", 0, 1);
    req[i] = 1'b0;
    lat_v = 0;
    do begin @(negedge clk); lat_v++; end while (!valid && lat_v < 20);
    if (!valid) chk("valid_timeout", 0, 1);
    chk($sformatf("op_result_r%0d_f%0d_d%0h", i, f, d), int'(result), exp);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int lg, lv, k;
    int gq[$];
    int gk[$];
    reset_n = 1'b0; req = 2'b00;
    func0 = '0; func1 = '0; data0 = '0; data1 = '0;
    repeat (3) @(negedge clk);
    chk("rst_gnt", int'(gnt), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_valid", int'(valid), 0);
    chk("rst_result", int'(result), 0);
    chk("rst_owner", int'(owner), 0);
    reset_n = 1'b1;
    chk_en = 1'b1;

    do_op(0, 3'b111, 4'h5, 8'h06, lg, lv);
    chk("first_gnt_latency", lg, 1);
    chk("first_valid_latency", lg + lv, 3);
    do_op(1, 3'b101, 4'hF, 8'h15, lg, lv);
    chk("owner_r1", int'(owner), 1);
    do_op(0, 3'b000, 4'h3, 8'h0F, lg, lv);

    do_reset();
    do_op(0, 3'b111, 4'h5, 8'h06, lg, lv);
    do_op(0, 3'b010, 4'h3, 8'h30, lg, lv);
    do_op(1, 3'b001, 4'h5, 8'h00, lg, lv);
    do_op(0, 3'b011, 4'h0, 8'h00, lg, lv);
    do_op(1, 3'b100, 4'hA, 8'hAA, lg, lv);
    do_op(0, 3'b011, 4'h0, 8'h01, lg, lv);
    do_op(0, 3'b010, 4'h7, 8'h80, lg, lv);
    do_op(1, 3'b111, 4'hF, 8'h10, lg, lv);
    do_op(0, 3'b110, 4'hF, 8'h0F, lg, lv);
    do_op(1, 3'b010, 4'h9, 8'h00, lg, lv);
    repeat (3) @(negedge clk);

    // Both requesters held high out of reset: grants alternate, 0 first.
    reset_n = 1'b0;
    func0 = 3'b111; data0 = 4'h1; func1 = 3'b111; data1 = 4'h2;
    req = 2'b11;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    for (int c = 1; c <= 12; c++) begin
      @(negedge clk);
      if (gnt != 2'b00) begin gq.push_back(int'(gnt)); gk.push_back(c); end
    end
    req = 2'b00;
    chk("rr_count", gq.size(), 4);
    if (gq.size() >= 4) begin
      chk("rr_g0", gq[0], 1); chk("rr_g1", gq[1], 2);
      chk("rr_g2", gq[2], 1); chk("rr_g3", gq[3], 2);
      chk("rr_c0", gk[0], 1); chk("rr_c3", gk[3], 10);
    end
    repeat (5) @(negedge clk);

    // Reset during EXEC: result clears at once, no strobe afterwards.
    func0 = 3'b111; data0 = 4'h2; req[0] = 1'b1;
    k = 0;
    do begin @(negedge clk); k++; end while (!gnt[0] && k < 20);
    if (!gnt[0]) chk("mid_gnt_timeout", 0, 1);
    req[0] = 1'b0;
    @(negedge clk);
    chk("mid_in_exec_busy", int'(busy), 1);
    #2 reset_n = 1'b0;
    #1;
    chk("mid_rst_busy", int'(busy), 0);
    chk("mid_rst_result", int'(result), 0);
    chk("mid_rst_valid", int'(valid), 0);
    @(negedge clk);
    reset_n = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      chk("mid_no_valid", int'(valid), 0);
    end
    do_op(0, 3'b111, 4'h5, 8'h06, lg, lv);
    chk("post_rst_gnt_latency", lg, 1);
    repeat (3) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
